// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one CPU-protocol slave port. A request that cannot be served
// at once is latched and replayed later, so neither master ever holds its request.
module mem_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, REPLAY} state_t;

  state_t            state, state_nxt;
  logic [1:0]        req, wr;
  logic [1:0][31:0]  in_a, in_d;
  logic [1:0]        pv, pwe;
  logic [1:0][31:0]  pa, pd;
  logic              owner, last_grant;
  logic [31:0]       cap_a, cap_d;
  logic [CNT_W-1:0]  cnt;

  logic              sel, cap_en, done, tmo;
  logic [1:0]        set, clr, rdy;
  logic [31:0]       bus_a, bus_d;
  logic              bus_we, bus_rd;

  assign req  = {m1_rd | m1_we, m0_rd | m0_we};
  assign wr   = {m1_we, m0_we};
  assign in_a = {m1_a, m0_a};
  assign in_d = {m1_d, m0_d};

  // Simultaneous candidates: m0 under fixed priority, otherwise the one not granted last.
  function automatic logic pick(input logic [1:0] cand, input logic lg);
    if (cand == 2'b11) return FIXED_PRIO ? 1'b0 : ~lg;
    return cand[1];
  endfunction

  assign tmo = (TIMEOUT > 0) && (state == BUSY) && !s_ready &&
               (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    cap_en    = 1'b0;
    done      = 1'b0;
    set       = '0;
    clr       = '0;
    rdy       = ~pv;
    bus_a     = cap_a;
    bus_d     = cap_d;
    bus_we    = 1'b0;
    bus_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          sel      = pick(req, last_grant);
          bus_a    = in_a[sel];
          bus_d    = in_d[sel];
          bus_we   = wr[sel];
          bus_rd   = ~wr[sel];
          rdy[sel] = s_ready;
          if (&req) set[~sel] = 1'b1;
          if (s_ready) begin
            state_nxt = (&req) ? REPLAY : IDLE;
          end else begin
            cap_en    = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        sel        = owner;
        rdy[owner] = s_ready | tmo;
        set[~owner] = req[~owner] & ~pv[~owner];
        if (s_ready | tmo) begin
          done      = 1'b1;
          state_nxt = (|(pv | set)) ? REPLAY : IDLE;
        end
      end
      REPLAY: begin
        sel      = pick(pv, last_grant);
        bus_a    = pa[sel];
        bus_d    = pd[sel];
        bus_we   = pwe[sel];
        bus_rd   = ~pwe[sel];
        rdy[sel] = s_ready;
        clr[sel] = 1'b1;
        set[~sel] = req[~sel] & ~pv[~sel];
        if (s_ready) begin
          state_nxt = (pv[~sel] | set[~sel]) ? REPLAY : IDLE;
        end else begin
          cap_en    = 1'b1;
          state_nxt = BUSY;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A request being latched this cycle must not look like a zero-wait completion.
    rdy = rdy & ~set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pv         <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      pv    <= (pv & ~clr) | set;
      if (cap_en) begin
        owner <= sel;
        cnt   <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done) last_grant <= owner;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (set[i]) begin
        pa[i]  <= in_a[i];
        pd[i]  <= in_d[i];
        pwe[i] <= wr[i];
      end
    end
    if (cap_en) begin
      cap_a <= bus_a;
      cap_d <= bus_d;
    end
  end

  assign s_a      = rst ? '0 : bus_a;
  assign s_d      = rst ? '0 : bus_d;
  assign s_we     = ~rst & bus_we;
  assign s_rd     = ~rst & bus_rd;
  assign m0_ready = rst | rdy[0];
  assign m1_ready = rst | rdy[1];
  assign err      = ~rst & tmo;
  assign m0_spo   = tmo ? 32'hffff_ffff : s_spo;
  assign m1_spo   = tmo ? 32'hffff_ffff : s_spo;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written timeout/reset sequences,
// and randomized traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int TMO = 4;
  localparam logic H = 1'b1, L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
  logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;
  logic [31:0] m0_spo, m1_spo, s_a, s_d;
  logic        m0_ready, m1_ready, s_we, s_rd, err;
  logic [31:0] f_m0_spo, f_m1_spo, f_s_a, f_s_d;
  logic        f_m0_ready, f_m1_ready, f_s_we, f_s_rd, f_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready), .err(err)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(f_m0_spo), .m0_ready(f_m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(f_m1_spo), .m1_ready(f_m1_ready),
    .s_a(f_s_a), .s_d(f_s_d), .s_we(f_s_we), .s_rd(f_s_rd), .s_spo(s_spo), .s_ready(s_ready), .err(f_err)
  );

  typedef struct {
    logic m0_rd, m0_we; logic [31:0] m0_a, m0_d;
    logic m1_rd, m1_we; logic [31:0] m1_a, m1_d;
    logic sr; logic [31:0] spo;
    logic x_rd, x_we, chk_a; logic [31:0] x_a, x_d;
    logic x_r0, x_r1, fp_chk; logic [31:0] fp_a;
  } vec_t;

  vec_t tbl [17];
  int n_chk = 0, n_pass = 0;

  // reference model state
  logic        q_rd [2], q_we [2], q_sr, q_rst;
  logic [31:0] q_a [2], q_d [2], q_spo;
  logic        pm_v [2], pm_we [2];
  logic [31:0] pm_a [2], pm_d [2];
  logic        bm_v, bm_o, lg_m;
  logic [31:0] bm_a, bm_d;
  int          bm_n;
  logic        acc [2], e_r [2];
  logic        e_rd, e_we, e_err, hv, sv, frc;
  logic [31:0] e_a, e_d, e_spo;
  int unsigned kk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_in(input logic r0, w0, input logic [31:0] a0, d0,
                        input logic r1, w1, input logic [31:0] a1, d1,
                        input logic sr, input logic [31:0] spo);
    m0_rd = r0; m0_we = w0; m0_a = a0; m0_d = d0;
    m1_rd = r1; m1_we = w1; m1_a = a1; m1_d = d1;
    s_ready = sr; s_spo = spo;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{H,L,32'h100,32'h11, H,L,32'h200,32'h22, L,32'h0,       H,L,H,32'h100,32'h11,      L,L, H,32'h100};
    tbl[1]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    L,32'h0,       L,L,H,32'h100,32'h11,      L,L, H,32'h100};
    tbl[2]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'haaaa0000,L,L,H,32'h100,32'h11,      H,L, H,32'h100};
    tbl[3]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    L,32'h0,       H,L,H,32'h200,32'h22,      H,L, H,32'h200};
    tbl[4]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    L,32'h0,       L,L,H,32'h200,32'h22,      H,L, H,32'h200};
    tbl[5]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'hbbbb1111,L,L,H,32'h200,32'h22,      H,H, H,32'h200};
    tbl[6]  = '{H,L,32'hf0000000,32'h0, L,L,32'h0,32'h0, H,32'h12345678,H,L,H,32'hf0000000,32'h0, H,H, H,32'hf0000000};
    tbl[7]  = '{H,L,32'h180,32'h18, L,L,32'h0,32'h0,    L,32'h0,       H,L,H,32'h180,32'h18,      L,H, H,32'h180};
    tbl[8]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'h5,       L,L,H,32'h180,32'h18,      H,H, H,32'h180};
    tbl[9]  = '{H,L,32'h300,32'h33, H,L,32'h400,32'h44, H,32'h6,       H,L,H,32'h400,32'h44,      L,H, H,32'h300};
    tbl[10] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'h7,       H,L,H,32'h300,32'h33,      H,H, H,32'h400};
    tbl[11] = '{H,L,32'h500,32'h55, L,L,32'h0,32'h0,    L,32'h0,       H,L,H,32'h500,32'h55,      L,H, H,32'h500};
    tbl[12] = '{L,L,32'h0,32'h0,    L,H,32'h10,32'h55aa,L,32'h0,       L,L,H,32'h500,32'h55,      L,L, H,32'h500};
    tbl[13] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'h8,       L,L,H,32'h500,32'h55,      H,L, H,32'h500};
    tbl[14] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'h9,       L,H,H,32'h10,32'h55aa,     H,H, H,32'h10};
    tbl[15] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,    H,32'ha,       L,L,L,32'h0,32'h0,         H,H, L,32'h0};
    tbl[16] = '{H,H,32'h20,32'h77,  L,L,32'h0,32'h0,    H,32'hb,       L,H,H,32'h20,32'h77,       H,H, H,32'h20};

    // reset state, with a request present to show it is masked
    rst = 1'b1;
    set_in(L, L, 32'h0, 32'h0, H, H, 32'h123, 32'h456, L, 32'h0);
    adv(); adv();
    #2;
    chk("rst s_rd", s_rd, 1'b0);   chk("rst s_we", s_we, 1'b0);
    chk("rst s_a", s_a, 32'h0);    chk("rst s_d", s_d, 32'h0);
    chk("rst m0_ready", m0_ready, 1'b1); chk("rst m1_ready", m1_ready, 1'b1);
    chk("rst err", err, 1'b0);
    adv();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].m0_rd, tbl[i].m0_we, tbl[i].m0_a, tbl[i].m0_d,
             tbl[i].m1_rd, tbl[i].m1_we, tbl[i].m1_a, tbl[i].m1_d, tbl[i].sr, tbl[i].spo);
      #2;
      chk($sformatf("tbl%0d s_rd", i), s_rd, tbl[i].x_rd);
      chk($sformatf("tbl%0d s_we", i), s_we, tbl[i].x_we);
      if (tbl[i].chk_a) begin
        chk($sformatf("tbl%0d s_a", i), s_a, tbl[i].x_a);
        chk($sformatf("tbl%0d s_d", i), s_d, tbl[i].x_d);
      end
      chk($sformatf("tbl%0d m0_ready", i), m0_ready, tbl[i].x_r0);
      chk($sformatf("tbl%0d m1_ready", i), m1_ready, tbl[i].x_r1);
      chk($sformatf("tbl%0d err", i), err, 1'b0);
      chk($sformatf("tbl%0d m0_spo", i), m0_spo, tbl[i].spo);
      if (tbl[i].fp_chk) chk($sformatf("tbl%0d fixed-prio s_a", i), f_s_a, tbl[i].fp_a);
      adv();
    end

    // watchdog: slave stuck busy
    set_in(H, L, 32'h600, 32'h66, L, L, 32'h0, 32'h0, L, 32'h0);
    #2;
    chk("tmo req m0_ready", m0_ready, 1'b0);
    adv();
    for (int k = 1; k <= TMO; k++) begin
      set_in(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, 32'h9999);
      #2;
      if (k < TMO) begin
        chk($sformatf("tmo busy%0d m0_ready", k), m0_ready, 1'b0);
        chk($sformatf("tmo busy%0d err", k), err, 1'b0);
      end else begin
        chk("tmo fire m0_ready", m0_ready, 1'b1);
        chk("tmo fire err", err, 1'b1);
        chk("tmo fire m0_spo", m0_spo, 32'hffffffff);
        chk("tmo fire m1_spo", m1_spo, 32'hffffffff);
        chk("tmo off m0_ready", f_m0_ready, 1'b0);
        chk("tmo off err", f_err, 1'b0);
      end
      adv();
    end
    set_in(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, H, 32'h0);
    #2;
    chk("tmo after err", err, 1'b0);
    chk("tmo after s_rd", s_rd, 1'b0);
    chk("tmo after m0_ready", m0_ready, 1'b1);
    chk("tmo off done m0_ready", f_m0_ready, 1'b1);
    adv();
    set_in(L, L, 32'h0, 32'h0, H, L, 32'h700, 32'h77, H, 32'h0);
    #2;
    chk("tmo idle s_rd", s_rd, 1'b1);
    chk("tmo idle s_a", s_a, 32'h700);
    chk("tmo idle m1_ready", m1_ready, 1'b1);
    adv();

    // reset while BUSY with m1 pending
    set_in(H, L, 32'h800, 32'h88, L, L, 32'h0, 32'h0, L, 32'h0);
    #2; chk("rstb m0_ready", m0_ready, 1'b0); adv();
    set_in(L, L, 32'h0, 32'h0, H, L, 32'h900, 32'h99, L, 32'h0);
    #2; chk("rstb m1_ready", m1_ready, 1'b0); chk("rstb s_a", s_a, 32'h800); adv();
    rst = 1'b1;
    set_in(H, L, 32'habc, 32'h0, L, L, 32'h0, 32'h0, L, 32'h0);
    #2;
    chk("rstb rst s_rd", s_rd, 1'b0); chk("rstb rst s_we", s_we, 1'b0);
    chk("rstb rst s_a", s_a, 32'h0);  chk("rstb rst s_d", s_d, 32'h0);
    chk("rstb rst m0_ready", m0_ready, 1'b1); chk("rstb rst m1_ready", m1_ready, 1'b1);
    chk("rstb rst err", err, 1'b0);
    adv();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, H, 32'h0);
      #2;
      chk($sformatf("rstb post%0d s_rd", k), s_rd, 1'b0);
      chk($sformatf("rstb post%0d s_we", k), s_we, 1'b0);
      chk($sformatf("rstb post%0d m0_ready", k), m0_ready, 1'b1);
      chk($sformatf("rstb post%0d m1_ready", k), m1_ready, 1'b1);
      adv();
    end

    // randomized traffic against the transaction model
    for (int n = 0; n < 3000; n++) begin
      q_rst = (n == 0) || ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        kk = $urandom_range(0, 7);
        q_rd[i] = (kk == 0) || (kk == 2);
        q_we[i] = (kk == 1) || (kk == 2);
        q_a[i]  = $urandom;
        q_d[i]  = $urandom;
      end
      q_sr  = ($urandom_range(0, 9) < 6);
      q_spo = $urandom;
      rst = q_rst;
      set_in(q_rd[0], q_we[0], q_a[0], q_d[0], q_rd[1], q_we[1], q_a[1], q_d[1], q_sr, q_spo);
      #2;
      hv = 1'b0; sv = 1'b0; frc = 1'b0;
      e_rd = 1'b0; e_we = 1'b0; e_a = 32'h0; e_d = 32'h0;
      if (q_rst) begin
        e_r[0] = 1'b1; e_r[1] = 1'b1;
        pm_v[0] = 1'b0; pm_v[1] = 1'b0; bm_v = 1'b0; lg_m = 1'b1; bm_n = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          acc[i] = (q_rd[i] | q_we[i]) && !pm_v[i] && !(bm_v && int'(bm_o) == i);
          e_r[i] = !pm_v[i] && !acc[i];
        end
        if (bm_v) begin
          hv = 1'b1; sv = bm_o; e_a = bm_a; e_d = bm_d;
          bm_n++;
          frc = !q_sr && (bm_n == TMO);
        end else if (pm_v[0] || pm_v[1]) begin
          hv = 1'b1;
          sv = (pm_v[0] && pm_v[1]) ? !lg_m : pm_v[1];
          e_a = pm_a[sv]; e_d = pm_d[sv]; e_we = pm_we[sv]; e_rd = !pm_we[sv];
          pm_v[sv] = 1'b0;
        end else if (acc[0] || acc[1]) begin
          hv = 1'b1;
          sv = (acc[0] && acc[1]) ? !lg_m : acc[1];
          e_a = q_a[sv]; e_d = q_d[sv]; e_we = q_we[sv]; e_rd = !q_we[sv];
          acc[sv] = 1'b0;
        end
        if (hv) e_r[sv] = q_sr | frc;
      end
      e_err = frc;
      e_spo = frc ? 32'hffffffff : q_spo;
      chk($sformatf("rnd%0d s_rd", n), s_rd, e_rd);
      chk($sformatf("rnd%0d s_we", n), s_we, e_we);
      chk($sformatf("rnd%0d m0_ready", n), m0_ready, e_r[0]);
      chk($sformatf("rnd%0d m1_ready", n), m1_ready, e_r[1]);
      chk($sformatf("rnd%0d err", n), err, e_err);
      if (q_rst || hv) begin
        chk($sformatf("rnd%0d s_a", n), s_a, e_a);
        chk($sformatf("rnd%0d s_d", n), s_d, e_d);
      end
      if (!q_rst) begin
        chk($sformatf("rnd%0d m0_spo", n), m0_spo, e_spo);
        chk($sformatf("rnd%0d m1_spo", n), m1_spo, e_spo);
        if (hv) begin
          if (q_sr || frc) begin
            if (bm_v) lg_m = sv;
            bm_v = 1'b0;
          end else if (!bm_v) begin
            bm_v = 1'b1; bm_o = sv; bm_a = e_a; bm_d = e_d; bm_n = 0;
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (acc[i]) begin
            pm_v[i] = 1'b1; pm_we[i] = q_we[i]; pm_a[i] = q_a[i]; pm_d[i] = q_d[i];
          end
        end
      end
      adv();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
